// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath package: root-engine FSM states, a constant-width
// helper and the default fractional precision used by the root blocks.
package arith_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_TRIAL = 3'd2,
    S_MUL   = 3'd3,
    S_CMP   = 3'd4,
    S_DONE  = 3'd5
  } root_state_e;

  localparam int ROOT_FRAC_DEFAULT = 10;

  // Ceiling log2 for sizing counters from parameters (elaboration-time use).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/root_pow_step.sv
// Trial-power register for the n-th root engine: loads the guess g, or steps
// p <= p*g by one multiply per cycle, and flags when that product exceeds T.
module root_pow_step #(
  parameter int W_T = 80,
  parameter int W_G = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 mul,
  input  logic [W_G-1:0]       g,
  input  logic [W_T-1:0]       t,
  output logic [W_T+W_G-1:0]   p,
  output logic                 mul_gt
);

  localparam int W_P = W_T + W_G;

  logic [W_P-1:0] p_q;
  logic [W_P-1:0] p_d;
  logic [W_P-1:0] prod;

  // Multiply and overflow compare. The engine only multiplies while p <= T, so
  // the low W_T bits hold the whole operand and the product fits in W_P bits.
  always_comb begin
    prod   = W_P'(p_q[W_T-1:0]) * W_P'(g);
    mul_gt = prod > W_P'(t);
  end

  // Next power: load the fresh guess, step the multiply, or hold.
  always_comb begin
    // NOTE: default assignment first so every path drives p_d and no latch is inferred.
    p_d = p_q;
    if (load)     p_d = W_P'(g);
    else if (mul) p_d = prod;
  end

  // Power register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for every flop so all registers update together.
    if (!rst_n) p_q <= '0;
    else        p_q <= p_d;
  end

  assign p = p_q;

endmodule

// File: rtl/nth_root_seq.sv
// Sequential fixed-point n-th root: out_root = floor(radicand^(1/n) * 2^FRAC).
// The root is built MSB-first; each trial raises the guess to the n-th power by
// repeated multiplication and compares it with T = radicand << (n*FRAC).
module nth_root_seq
  import arith_pkg::*;
#(
  parameter int W_IN  = 10,
  parameter int FRAC  = ROOT_FRAC_DEFAULT,
  parameter int W_N   = 3,
  parameter int N_MAX = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W_IN-1:0]      in_radicand,
  input  logic [W_N-1:0]       in_n,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W_IN+FRAC-1:0] out_root,
  output logic                 out_exact,
  output logic                 out_err
);

  localparam int W_OUT = W_IN + FRAC;
  localparam int W_T   = W_IN + N_MAX * FRAC;
  localparam int W_P   = W_T + W_OUT;
  localparam int W_K   = clog2(N_MAX + 1);

  root_state_e      state_q, state_d;
  logic [W_IN-1:0]  rad_q, rad_d;
  logic [W_N-1:0]   n_q, n_d;
  logic [W_T-1:0]   t_q, t_d;
  logic [W_OUT-1:0] res_q, res_d;
  logic [W_OUT-1:0] bit_q, bit_d;
  logic [W_K-1:0]   k_q, k_d;
  logic             exact_q, exact_d;
  logic             err_q, err_d;

  logic             accept;
  logic             n_bad;
  logic             k_last;
  logic [W_OUT-1:0] g;
  logic [W_P-1:0]   p;
  logic             mul_gt;
  logic             p_lt_t;
  logic             p_eq_t;

  // Decode helpers shared by the next-state and datapath logic.
  always_comb begin
    accept = in_valid && (state_q == S_IDLE);
    n_bad  = (n_q == '0) || (n_q > W_N'(N_MAX));
    k_last = (int'(k_q) + 1) == int'(n_q);
    g      = res_q | bit_q;
    p_lt_t = p < W_P'(t_q);
    p_eq_t = p == W_P'(t_q);
  end

  root_pow_step #(
    .W_T (W_T),
    .W_G (W_OUT)
  ) u_pow (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (state_q == S_TRIAL),
    .mul    (state_q == S_MUL),
    .g      (g),
    .t      (t_q),
    .p      (p),
    .mul_gt (mul_gt)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous to clk, so it is tested inside the clocked block.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_CHECK;
      S_CHECK: state_d = (n_bad || rad_q == '0) ? S_DONE : S_TRIAL;
      S_TRIAL: state_d = (n_q == W_N'(1)) ? S_CMP : S_MUL;
      S_MUL:   if (mul_gt || k_last) state_d = S_CMP;
      S_CMP: begin
        if (p_eq_t || bit_q == W_OUT'(1)) state_d = S_DONE;
        else                              state_d = S_TRIAL;
      end
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  // Datapath updates: capture on accept, initialise in CHECK, refine in CMP.
  always_comb begin
    rad_d   = rad_q;
    n_d     = n_q;
    t_d     = t_q;
    res_d   = res_q;
    bit_d   = bit_q;
    k_d     = k_q;
    exact_d = exact_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          rad_d = in_radicand;
          n_d   = in_n;
          t_d   = W_T'(in_radicand) << (int'(in_n) * FRAC);
        end
      end
      S_CHECK: begin
        res_d   = '0;
        err_d   = n_bad;
        exact_d = !n_bad && (rad_q == '0);
        bit_d   = {1'b1, {(W_OUT-1){1'b0}}};
      end
      S_TRIAL: k_d = W_K'(1);
      S_MUL:   k_d = k_q + W_K'(1);
      S_CMP: begin
        if (p_lt_t || p_eq_t) res_d = res_q | bit_q;
        if (p_eq_t)           exact_d = 1'b1;
        bit_d = bit_q >> 1;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rad_q   <= '0;
      n_q     <= '0;
      t_q     <= '0;
      res_q   <= '0;
      bit_q   <= '0;
      k_q     <= '0;
      exact_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      rad_q   <= rad_d;
      n_q     <= n_d;
      t_q     <= t_d;
      res_q   <= res_d;
      bit_q   <= bit_d;
      k_q     <= k_d;
      exact_q <= exact_d;
      err_q   <= err_d;
    end
  end

  assign out_root  = res_q;
  assign out_exact = exact_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_nth_root_seq.sv
// Directed bench for nth_root_seq: reset state, square/cube/n=1 roots, bad order,
// zero radicand, output back-pressure and a reset in the middle of an operation.
module tb_nth_root_seq;

  localparam int W_IN    = 10;
  localparam int FRAC    = 10;
  localparam int W_N     = 3;
  localparam int W_OUT   = W_IN + FRAC;
  localparam int LAT_MAX = 2 + W_OUT * 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [W_IN-1:0]  in_radicand;
  logic [W_N-1:0]   in_n;
  logic             out_valid;
  logic             out_ready;
  logic [W_OUT-1:0] out_root;
  logic             out_exact;
  logic             out_err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  nth_root_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_radicand (in_radicand),
    .in_n        (in_n),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_root    (out_root),
    .out_exact   (out_exact),
    .out_err     (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request from idle and wait (bounded) for out_valid. lat counts the
  // accept edge as cycle 1. Inputs are scrambled after accept; they must be ignored.
  task automatic run_req(input logic [W_IN-1:0] rad, input logic [W_N-1:0] n,
                         output logic [W_OUT-1:0] root, output logic exact,
                         output logic err, output int lat);
    in_valid    = 1'b1;
    in_radicand = rad;
    in_n        = n;
    @(posedge clk); #1;
    in_valid    = 1'b0;
    in_radicand = ~rad;
    in_n        = ~n;
    lat = 1;
    while (!out_valid && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    root  = out_root;
    exact = out_exact;
    err   = out_err;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", in_ready);
    else pass_cnt++;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (out_root !== '0) $display("FAIL reset_out_root: got %0d want 0", out_root);
    else pass_cnt++;
    total_cnt++;
    if (out_exact !== 1'b0) $display("FAIL reset_out_exact: got %0b want 0", out_exact);
    else pass_cnt++;
    total_cnt++;
    if (out_err !== 1'b0) $display("FAIL reset_out_err: got %0b want 0", out_err);
    else pass_cnt++;
  endtask

  task automatic test_square();
    logic [W_OUT-1:0] root;
    logic exact, err;
    int lat;
    // sqrt(16) = 4.0 -> 4096, exact
    run_req(10'd16, 3'd2, root, exact, err, lat);
    total_cnt++;
    if (root !== 20'd4096 || exact !== 1'b1 || err !== 1'b0 || lat > LAT_MAX)
      $display("FAIL sqrt16: root=%0d exact=%0b err=%0b lat=%0d want 4096/1/0 lat<=%0d",
               root, exact, err, lat, LAT_MAX);
    else pass_cnt++;
    release_out();
    // sqrt(2)*1024 = 1448.15 -> 1448, inexact
    run_req(10'd2, 3'd2, root, exact, err, lat);
    total_cnt++;
    if (root !== 20'd1448 || exact !== 1'b0 || err !== 1'b0 || lat > LAT_MAX)
      $display("FAIL sqrt2: root=%0d exact=%0b err=%0b lat=%0d want 1448/0/0",
               root, exact, err, lat);
    else pass_cnt++;
    release_out();
  endtask

  task automatic test_cube();
    logic [W_OUT-1:0] root;
    logic exact, err;
    int lat;
    // cbrt(1000) = 10.0 -> 10240, exact, terminates early
    run_req(10'd1000, 3'd3, root, exact, err, lat);
    total_cnt++;
    if (root !== 20'd10240 || exact !== 1'b1 || err !== 1'b0)
      $display("FAIL cbrt1000: root=%0d exact=%0b err=%0b want 10240/1/0", root, exact, err);
    else pass_cnt++;
    total_cnt++;
    if (lat > LAT_MAX / 2)
      $display("FAIL cbrt1000_early: lat=%0d want <=%0d", lat, LAT_MAX / 2);
    else pass_cnt++;
    release_out();
  endtask

  task automatic test_bad_n_and_zero();
    logic [W_OUT-1:0] root;
    logic exact, err;
    int lat;
    run_req(10'd500, 3'd0, root, exact, err, lat);
    total_cnt++;
    if (root !== '0 || err !== 1'b1 || exact !== 1'b0 || lat != 2)
      $display("FAIL n0_err: root=%0d err=%0b exact=%0b lat=%0d want 0/1/0 lat=2",
               root, err, exact, lat);
    else pass_cnt++;
    release_out();
    // 1023^(1/7)*1024 = 2756.02 -> 2756
    run_req(10'd1023, 3'd7, root, exact, err, lat);
    total_cnt++;
    if (root !== 20'd2756 || exact !== 1'b0 || err !== 1'b0 || lat > LAT_MAX)
      $display("FAIL root7_1023: root=%0d exact=%0b err=%0b lat=%0d want 2756/0/0",
               root, exact, err, lat);
    else pass_cnt++;
    release_out();
    run_req(10'd0, 3'd3, root, exact, err, lat);
    total_cnt++;
    if (root !== '0 || exact !== 1'b1 || err !== 1'b0 || lat != 2)
      $display("FAIL zero_rad: root=%0d exact=%0b err=%0b lat=%0d want 0/1/0 lat=2",
               root, exact, err, lat);
    else pass_cnt++;
    release_out();
  endtask

  task automatic test_n1();
    logic [W_OUT-1:0] root;
    logic exact, err;
    int lat;
    run_req(10'd5, 3'd1, root, exact, err, lat);
    total_cnt++;
    if (root !== 20'd5120 || exact !== 1'b1 || err !== 1'b0 || lat > LAT_MAX)
      $display("FAIL n1_5: root=%0d exact=%0b err=%0b want 5120/1/0", root, exact, err);
    else pass_cnt++;
    release_out();
  endtask

  task automatic test_hold();
    logic [W_OUT-1:0] root;
    logic exact, err;
    int lat;
    int bad;
    run_req(10'd16, 3'd2, root, exact, err, lat);
    bad = 0;
    in_valid = 1'b1;  // must not be accepted while a result is pending
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_root !== 20'd4096 || out_exact !== 1'b1 ||
          in_ready !== 1'b0) bad++;
    end
    total_cnt++;
    if (bad != 0)
      $display("FAIL hold_stable: %0d bad cycles, last valid=%0b root=%0d in_ready=%0b want 0 bad",
               bad, out_valid, out_root, in_ready);
    else pass_cnt++;
    in_valid = 1'b0;
    release_out();
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL hold_release: out_valid=%0b in_ready=%0b want 0/1", out_valid, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_op();
    logic [W_OUT-1:0] root;
    logic exact, err;
    int lat;
    in_valid    = 1'b1;
    in_radicand = 10'd1023;
    in_n        = 3'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end  // now multiplying
    total_cnt++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL busy_before_reset: in_ready=%0b out_valid=%0b want 0/0", in_ready, out_valid);
    else pass_cnt++;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    test_reset();
    run_req(10'd2, 3'd2, root, exact, err, lat);
    total_cnt++;
    if (root !== 20'd1448 || exact !== 1'b0 || err !== 1'b0 || lat > LAT_MAX)
      $display("FAIL after_reset_sqrt2: root=%0d exact=%0b err=%0b want 1448/0/0", root, exact, err);
    else pass_cnt++;
    release_out();
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_radicand = '0;
    in_n        = '0;
    out_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_square();
    test_cube();
    test_bad_n_and_zero();
    test_n1();
    test_hold();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
